// File: rtl/ps2_kbd_pkg.sv
// Shared types, Set-2 scan-code constants and the make-code to ASCII translation.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_t;

  localparam logic [7:0] SC_F0      = 8'hF0;
  localparam logic [7:0] SC_E0      = 8'hE0;
  localparam logic [7:0] SC_AA      = 8'hAA;
  localparam logic [7:0] SC_FA      = 8'hFA;
  localparam logic [7:0] SC_EE      = 8'hEE;
  localparam logic [7:0] SC_FE      = 8'hFE;
  localparam logic [7:0] SC_00      = 8'h00;
  localparam logic [7:0] SC_FF      = 8'hFF;
  localparam logic [7:0] SC_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_SHIFT_R = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_CAPS    = 8'h58;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] LED_CMD    = 8'hED;

  // Keyboard self-test, ack, echo and resend responses carry no key information.
  function automatic logic is_ignored(input logic [7:0] code);
    return (code == SC_AA) || (code == SC_FA) || (code == SC_EE) ||
           (code == SC_FE) || (code == SC_00) || (code == SC_FF);
  endfunction

  // Returns {hit, ascii}; hit=0 means the code produces no character.
  function automatic logic [8:0] set2_to_ascii(input logic [7:0] code, input logic shift,
                                               input logic caps, input logic ctrl);
    logic       is_letter;
    logic       is_digit;
    logic [4:0] idx;
    logic [3:0] dig;
    logic       hit;
    logic [7:0] ascii;
    is_letter = 1'b1;
    is_digit  = 1'b0;
    idx       = 5'd0;
    dig       = 4'd0;
    hit       = 1'b0;
    ascii     = 8'h00;
    case (code)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
      8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
      8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
      8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
      8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
    case (code)
      8'h45: begin is_digit = 1'b1; dig = 4'd0; end
      8'h16: begin is_digit = 1'b1; dig = 4'd1; end
      8'h1E: begin is_digit = 1'b1; dig = 4'd2; end
      8'h26: begin is_digit = 1'b1; dig = 4'd3; end
      8'h25: begin is_digit = 1'b1; dig = 4'd4; end
      8'h2E: begin is_digit = 1'b1; dig = 4'd5; end
      8'h36: begin is_digit = 1'b1; dig = 4'd6; end
      8'h3D: begin is_digit = 1'b1; dig = 4'd7; end
      8'h3E: begin is_digit = 1'b1; dig = 4'd8; end
      8'h46: begin is_digit = 1'b1; dig = 4'd9; end
      8'h29: begin hit = 1'b1; ascii = 8'h20; end
      8'h5A: begin hit = 1'b1; ascii = 8'h0D; end
      8'h66: begin hit = 1'b1; ascii = 8'h08; end
      8'h0D: begin hit = 1'b1; ascii = 8'h09; end
      8'h76: begin hit = 1'b1; ascii = 8'h1B; end
      default: ;
    endcase
    if (is_letter) begin
      hit = 1'b1;
      if (ctrl)              ascii = {3'b000, idx} + 8'h01;
      else if (shift ^ caps) ascii = 8'h41 + {3'b000, idx};
      else                   ascii = 8'h61 + {3'b000, idx};
    end else if (is_digit) begin
      hit = 1'b1;
      if (shift) begin
        case (dig)
          4'd0: ascii = 8'h29;  4'd1: ascii = 8'h21;  4'd2: ascii = 8'h40;
          4'd3: ascii = 8'h23;  4'd4: ascii = 8'h24;  4'd5: ascii = 8'h25;
          4'd6: ascii = 8'h5E;  4'd7: ascii = 8'h26;  4'd8: ascii = 8'h2A;
          default: ascii = 8'h28;
        endcase
      end else begin
        ascii = 8'h30 + {4'h0, dig};
      end
    end
    return {hit, ascii};
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Synchronous first-word-fall-through FIFO for decoded ASCII characters.
module ps2_key_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  assign o_data = o_empty ? 8'h00 : r_mem[r_rd];

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scan byte decoder: prefix FSM, modifier tracking, ASCII FIFO.
// Build with PS2_CAPS_LED_EN defined to emit CapsLock LED commands on led_req/led_byte.
module ps2_key_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_ascii,
  output logic       caps_lock,
  output logic       overflow,
  output logic       led_req,
  output logic [7:0] led_byte,
  input  logic       led_ack
);
  kbd_state_t r_state;
  logic       r_shift_l;
  logic       r_shift_r;
  logic       r_ctrl;
  logic       r_caps;
  logic       r_caps_held;
  logic       r_overflow;
  logic [8:0] w_map;
  logic       w_push;
  logic [7:0] w_push_data;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_toggle;

  assign w_map = set2_to_ascii(in_byte, r_shift_l | r_shift_r, r_caps, r_ctrl);

  always_comb begin
    w_push      = 1'b0;
    w_push_data = w_map[7:0];
    if (in_valid) begin
      if (r_state == ST_IDLE && in_byte != SC_F0 && in_byte != SC_E0 && !is_ignored(in_byte)) begin
        w_push = w_map[8];
      end else if (r_state == ST_EXT && in_byte == SC_ENTER) begin
        w_push      = 1'b1;
        w_push_data = 8'h0D;
      end
    end
  end

  // Holding CapsLock repeats its make code; only the first one toggles.
  assign w_toggle = in_valid & (r_state == ST_IDLE) & (in_byte == SC_CAPS) & ~r_caps_held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift_l   <= 1'b0;
      r_shift_r   <= 1'b0;
      r_ctrl      <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else if (in_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (in_byte == SC_F0) begin
            r_state <= ST_BRK;
          end else if (in_byte == SC_E0) begin
            r_state <= ST_EXT;
          end else if (!is_ignored(in_byte)) begin
            if (in_byte == SC_SHIFT_L) r_shift_l <= 1'b1;
            if (in_byte == SC_SHIFT_R) r_shift_r <= 1'b1;
            if (in_byte == SC_CTRL)    r_ctrl    <= 1'b1;
            if (in_byte == SC_CAPS) begin
              if (!r_caps_held) r_caps <= ~r_caps;
              r_caps_held <= 1'b1;
            end
          end
        end
        ST_BRK: begin
          if (in_byte == SC_SHIFT_L) r_shift_l   <= 1'b0;
          if (in_byte == SC_SHIFT_R) r_shift_r   <= 1'b0;
          if (in_byte == SC_CTRL)    r_ctrl      <= 1'b0;
          if (in_byte == SC_CAPS)    r_caps_held <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_EXT: begin
          if (in_byte == SC_F0) begin
            r_state <= ST_EXT_BRK;
          end else begin
            if (in_byte == SC_CTRL) r_ctrl <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          if (in_byte == SC_CTRL) r_ctrl <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_pop = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_overflow <= 1'b0;
    else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
  end

  ps2_key_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_data (w_push_data),
    .i_pop  (w_pop),
    .o_data (out_ascii),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign out_valid = ~w_empty;
  assign caps_lock = r_caps;
  assign overflow  = r_overflow;

`ifdef PS2_CAPS_LED_EN
  logic       r_led_req;
  logic [7:0] r_led_byte;
  logic       r_led_stage;
  logic       r_led_restart;

  // A toggle during a pending command restarts at 0xED once the current byte is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_req     <= 1'b0;
      r_led_byte    <= 8'h00;
      r_led_stage   <= 1'b0;
      r_led_restart <= 1'b0;
    end else if (r_led_req && led_ack) begin
      if (r_led_restart || w_toggle) begin
        r_led_byte    <= LED_CMD;
        r_led_stage   <= 1'b0;
        r_led_restart <= 1'b0;
      end else if (!r_led_stage) begin
        r_led_byte  <= {5'b00000, r_caps, 2'b00};
        r_led_stage <= 1'b1;
      end else begin
        r_led_req   <= 1'b0;
        r_led_byte  <= 8'h00;
        r_led_stage <= 1'b0;
      end
    end else if (w_toggle) begin
      if (!r_led_req) begin
        r_led_req   <= 1'b1;
        r_led_byte  <= LED_CMD;
        r_led_stage <= 1'b0;
      end else begin
        r_led_restart <= 1'b1;
      end
    end
  end

  assign led_req  = r_led_req;
  assign led_byte = r_led_byte;
`else
  logic w_unused_led;
  assign w_unused_led = led_ack ^ w_toggle;
  assign led_req      = 1'b0;
  assign led_byte     = 8'h00;
`endif

endmodule
